// File: rtl/wm8731_init_seq.sv
// wm8731_init_seq: walks the WM8731 power-up register table through the I2C writer, retrying NACKed entries
module wm8731_init_seq #(
  parameter logic [6:0] DEV_ADDR   = 7'h1A,
  parameter int         NUM_REGS   = 10,
  parameter int         GAP_CYCLES = 1000,
  parameter int         MIN_BUSY   = 4640,
  parameter int         HI_TIMEOUT = 64,
  parameter int         LO_TIMEOUT = 8000,
  parameter int         RETRY_MAX  = 3
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  output logic       error,
  output logic       active,
  output logic       cfg_action,
  input  logic       cfg_busy,
  output logic [6:0] cfg_dev_addr,
  output logic [6:0] cfg_reg_addr,
  output logic [8:0] cfg_reg_data,
  output logic [3:0] entry_idx,
  output logic [1:0] retry_cnt
);
  localparam logic [15:0] GAP_END = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] HI_END  = 16'(HI_TIMEOUT - 1);
  localparam logic [15:0] LO_END  = 16'(LO_TIMEOUT - 1);
  localparam logic [15:0] MIN_B   = 16'(MIN_BUSY);
  localparam logic [3:0]  LAST    = 4'(NUM_REGS - 1);
  localparam logic [1:0]  RMAX    = 2'(RETRY_MAX);
  typedef enum logic [3:0] {IDLE, LOAD, REQ, WAIT_HI, WAIT_LO, CHECK, GAP, DONE, FAIL} state_t;
  state_t      state;
  logic [15:0] cyc;
  logic [15:0] cyc_inc;
  function automatic logic [15:0] entry(input logic [3:0] i);
    case (i)
      4'd0:    entry = {7'd15, 9'h000};
      4'd1:    entry = {7'd0,  9'h017};
      4'd2:    entry = {7'd1,  9'h017};
      4'd3:    entry = {7'd2,  9'h079};
      4'd4:    entry = {7'd3,  9'h079};
      4'd5:    entry = {7'd4,  9'h012};
      4'd6:    entry = {7'd5,  9'h000};
      4'd7:    entry = {7'd6,  9'h000};
      4'd8:    entry = {7'd7,  9'h001};
      4'd9:    entry = {7'd9,  9'h001};
      default: entry = 16'h0000;
    endcase
  endfunction
  assign cyc_inc      = &cyc ? cyc : cyc + 16'd1;
  assign cfg_dev_addr = DEV_ADDR;
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      state        <= IDLE;
      cyc          <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      active       <= 1'b0;
      cfg_action   <= 1'b0;
      entry_idx    <= '0;
      retry_cnt    <= '0;
      cfg_reg_addr <= '0;
      cfg_reg_data <= '0;
    end else begin
      cfg_action <= 1'b0;
      case (state)
        IDLE, DONE, FAIL: if (start) begin
          state     <= LOAD;
          entry_idx <= '0;
          retry_cnt <= '0;
          done      <= 1'b0;
          error     <= 1'b0;
          active    <= 1'b1;
        end
        LOAD: begin
          {cfg_reg_addr, cfg_reg_data} <= entry(entry_idx);
          if (!cfg_busy) begin
            state      <= REQ;
            cfg_action <= 1'b1;
          end
        end
        REQ: begin
          cyc   <= '0;
          state <= WAIT_HI;
        end
        WAIT_HI: if (cfg_busy) begin
          cyc   <= '0;
          state <= WAIT_LO;
        end else if (cyc >= HI_END) begin
          state  <= FAIL;
          error  <= 1'b1;
          active <= 1'b0;
        end else cyc <= cyc_inc;
        WAIT_LO: if (!cfg_busy) state <= CHECK;
        else if (cyc >= LO_END) begin
          state  <= FAIL;
          error  <= 1'b1;
          active <= 1'b0;
        end else cyc <= cyc_inc;
        CHECK: begin
          cyc <= '0;
          if (cyc >= MIN_B) begin
            entry_idx <= entry_idx + 4'd1;
            retry_cnt <= '0;
            state     <= entry_idx == LAST ? DONE : GAP;
            done      <= entry_idx == LAST;
            active    <= entry_idx != LAST;
          end else if (retry_cnt < RMAX) begin
            retry_cnt <= retry_cnt + 2'd1;
            state     <= GAP;
          end else begin
            state  <= FAIL;
            error  <= 1'b1;
            active <= 1'b0;
          end
        end
        GAP: if (cyc >= GAP_END) state <= LOAD;
        else cyc <= cyc_inc;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wm8731_init_seq.sv
// tb_wm8731_init_seq: directed self-checking bench for wm8731_init_seq with a behavioural I2C writer model
module tb_wm8731_init_seq;
  logic       sysclk;
  logic       reset;
  logic       start;
  logic       done;
  logic       error;
  logic       active;
  logic       cfg_action;
  logic       cfg_busy;
  logic [6:0] cfg_dev_addr;
  logic [6:0] cfg_reg_addr;
  logic [8:0] cfg_reg_data;
  logic [3:0] entry_idx;
  logic [1:0] retry_cnt;
  int tests = 0;
  int failed = 0;
  logic [6:0] log_a[$];
  logic [8:0] log_d[$];
  logic [6:0] nack_addr = 7'h7F;
  int         nack_left = 0;
  bit         never_rise = 0;
  int         max_retry = 0;
  int         hs_viol = 0;
  int         stab_viol = 0;
  logic [6:0] ea [10] = '{7'd15, 7'd0, 7'd1, 7'd2, 7'd3, 7'd4, 7'd5, 7'd6, 7'd7, 7'd9};
  logic [8:0] ed [10] = '{9'h000, 9'h017, 9'h017, 9'h079, 9'h079, 9'h012, 9'h000, 9'h000, 9'h001, 9'h001};
  wm8731_init_seq #(
    .GAP_CYCLES(10), .MIN_BUSY(46), .HI_TIMEOUT(64), .LO_TIMEOUT(80)
  ) dut (
    .sysclk(sysclk), .reset(reset), .start(start), .done(done), .error(error), .active(active),
    .cfg_action(cfg_action), .cfg_busy(cfg_busy), .cfg_dev_addr(cfg_dev_addr),
    .cfg_reg_addr(cfg_reg_addr), .cfg_reg_data(cfg_reg_data), .entry_idx(entry_idx), .retry_cnt(retry_cnt)
  );
  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;
  // writer model: busy 48 cycles for an ack, 30 for a NACK abort, starting 2 cycles after the action
  initial begin
    int len;
    cfg_busy = 1'b0;
    forever begin
      @(negedge sysclk);
      if (cfg_action === 1'b1) begin
        log_a.push_back(cfg_reg_addr);
        log_d.push_back(cfg_reg_data);
        if (!never_rise) begin
          len = 48;
          if (cfg_reg_addr == nack_addr && nack_left != 0) begin
            len = 30;
            if (nack_left > 0) nack_left--;
          end
          repeat (2) @(negedge sysclk);
          cfg_busy = 1'b1;
          repeat (len) @(negedge sysclk);
          cfg_busy = 1'b0;
        end
      end
    end
  end
  initial forever begin
    @(negedge sysclk);
    if (int'(retry_cnt) > max_retry) max_retry = int'(retry_cnt);
    if (cfg_action === 1'b1 && cfg_busy === 1'b1) hs_viol++;
    if (active === 1'b1 && cfg_busy === 1'b1 && log_a.size() > 0 &&
        (cfg_reg_addr !== log_a[$] || cfg_reg_data !== log_d[$])) stab_viol++;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic pulse_start();
    @(negedge sysclk);
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
  endtask
  task automatic wait_end(input string tag);
    for (int i = 0; i < 4000 && !(done || error); i++) @(negedge sysclk);
    chk(tag, 32'(done | error), 32'd1);
  endtask
  task automatic wait_log(input int n);
    for (int i = 0; i < 4000 && log_a.size() < n; i++) @(negedge sysclk);
    chk("log_reach", 32'(log_a.size() >= n), 32'd1);
  endtask
  task automatic chk_seq(input string tag);
    chk({tag, "_count"}, 32'(log_a.size()), 32'd10);
    for (int i = 0; i < 10 && i < log_a.size(); i++)
      chk($sformatf("%s_e%0d", tag, i), {16'd0, log_a[i], log_d[i]}, {16'd0, ea[i], ed[i]});
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_active"}, 32'(active), 32'd0);
    chk({tag, "_action"}, 32'(cfg_action), 32'd0);
    chk({tag, "_idx"}, 32'(entry_idx), 32'd0);
    chk({tag, "_retry"}, 32'(retry_cnt), 32'd0);
    chk({tag, "_addr"}, 32'(cfg_reg_addr), 32'd0);
    chk({tag, "_data"}, 32'(cfg_reg_data), 32'd0);
  endtask
  initial begin
    int n;
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge sysclk);
    chk_reset_vals("rst");
    chk("dev_addr", 32'(cfg_dev_addr), 32'h1A);
    reset = 1'b1;
    // all entries acked; first action exactly two cycles after start
    @(negedge sysclk);
    start = 1'b1;
    @(negedge sysclk);
    start = 1'b0;
    chk("lat_load", 32'(cfg_action), 32'd0);
    @(negedge sysclk);
    chk("lat_req", 32'(cfg_action), 32'd1);
    wait_end("t1_end");
    chk("t1_done", 32'(done), 32'd1);
    chk("t1_error", 32'(error), 32'd0);
    chk("t1_retry", 32'(retry_cnt), 32'd0);
    chk("t1_active", 32'(active), 32'd0);
    chk("t1_idx", 32'(entry_idx), 32'd10);
    chk_seq("t1");
    // entry 3 NACKed once, then acked
    log_a.delete(); log_d.delete();
    nack_addr = 7'd2; nack_left = 1; max_retry = 0;
    pulse_start();
    wait_end("t2_end");
    chk("t2_done", 32'(done), 32'd1);
    chk("t2_retry", 32'(retry_cnt), 32'd0);
    chk("t2_max_retry", 32'(max_retry), 32'd1);
    chk("t2_count", 32'(log_a.size()), 32'd11);
    chk("t2_first", {16'd0, log_a[3], log_d[3]}, {16'd0, ea[3], ed[3]});
    chk("t2_reissue", {16'd0, log_a[4], log_d[4]}, {16'd0, ea[3], ed[3]});
    chk("t2_next", {16'd0, log_a[5], log_d[5]}, {16'd0, ea[4], ed[4]});
    chk("t2_last", {16'd0, log_a[10], log_d[10]}, {16'd0, ea[9], ed[9]});
    // entry 5 always NACKed: four attempts then FAIL
    log_a.delete(); log_d.delete();
    nack_addr = 7'd4; nack_left = -1;
    pulse_start();
    wait_end("t3_end");
    chk("t3_error", 32'(error), 32'd1);
    chk("t3_done", 32'(done), 32'd0);
    chk("t3_idx", 32'(entry_idx), 32'd5);
    chk("t3_retry", 32'(retry_cnt), 32'd3);
    repeat (200) @(negedge sysclk);
    chk("t3_count", 32'(log_a.size()), 32'd9);
    for (int i = 5; i < 9 && i < log_a.size(); i++)
      chk($sformatf("t3_att%0d", i - 5), {16'd0, log_a[i], log_d[i]}, {16'd0, ea[5], ed[5]});
    nack_addr = 7'h7F; nack_left = 0;
    // busy never rises: 64-cycle window after the action, FAIL on the following edge
    log_a.delete(); log_d.delete();
    never_rise = 1'b1;
    pulse_start();
    for (int i = 0; i < 10 && cfg_action !== 1'b1; i++) @(negedge sysclk);
    chk("t4_action", 32'(cfg_action), 32'd1);
    n = 0;
    while (!error && n < 200) begin
      @(negedge sysclk);
      n++;
    end
    chk("t4_timeout_cycles", 32'(n), 32'd65);
    chk("t4_error", 32'(error), 32'd1);
    chk("t4_idx", 32'(entry_idx), 32'd0);
    chk("t4_count", 32'(log_a.size()), 32'd1);
    never_rise = 1'b0;
    // reset during entry 4's busy window, then a clean restart while the writer is still busy
    log_a.delete(); log_d.delete();
    pulse_start();
    wait_log(5);
    repeat (10) @(negedge sysclk);
    chk("t5_busy", 32'(cfg_busy), 32'd1);
    reset = 1'b0;
    @(negedge sysclk);
    chk_reset_vals("t5_rst");
    reset = 1'b1;
    log_a.delete(); log_d.delete();
    pulse_start();
    wait_end("t5_end");
    chk("t5_done", 32'(done), 32'd1);
    chk_seq("t5");
    // start pulses mid-run are ignored
    log_a.delete(); log_d.delete();
    pulse_start();
    wait_log(3);
    pulse_start();
    wait_log(7);
    pulse_start();
    wait_end("t6_end");
    chk("t6_done", 32'(done), 32'd1);
    chk_seq("t6");
    // reset and start in the same cycle: reset wins, no run begins
    log_a.delete(); log_d.delete();
    @(negedge sysclk);
    reset = 1'b0;
    start = 1'b1;
    @(negedge sysclk);
    reset = 1'b1;
    start = 1'b0;
    chk("t7_active", 32'(active), 32'd0);
    chk("t7_done", 32'(done), 32'd0);
    repeat (20) @(negedge sysclk);
    chk("t7_active_late", 32'(active), 32'd0);
    chk("t7_count", 32'(log_a.size()), 32'd0);
    chk("handshake_viol", 32'(hs_viol), 32'd0);
    chk("stability_viol", 32'(stab_viol), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
